// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file and the hazard unit.
package reg_file_pkg;

    localparam int unsigned REG_ZERO    = 0;
    localparam int unsigned MAX_READ    = 4;
    localparam int unsigned MAX_WRITE   = 2;
    localparam int unsigned MAX_FIELD_W = 64;
    localparam int unsigned MAX_BUS_W   = MAX_READ * MAX_FIELD_W;

    // Result of write-port arbitration for one register.
    typedef struct packed {
        logic       hit;
        logic [0:0] port;
    } wr_sel_t;

    // Extract field p of width w from a packed bus (zero-extended to MAX_FIELD_W).
    function automatic logic [MAX_FIELD_W-1:0] get_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          p,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_FIELD_W-1:0] mask;
        shifted = bus >> (p * w);
        mask    = (w >= MAX_FIELD_W) ? '1
                                     : ((MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1));
        return MAX_FIELD_W'(shifted) & mask;
    endfunction

    // Fixed priority: the highest-indexed hitting write port wins.
    function automatic wr_sel_t wr_resolve(input logic [MAX_WRITE-1:0] hits);
        wr_sel_t sel;
        sel = '0;
        for (int unsigned p = 0; p < MAX_WRITE; p++) begin
            if (hits[p]) begin
                sel.hit  = 1'b1;
                sel.port = 1'(p);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard; a reservation beats a same-edge writeback clear.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_REGS-1:0] i_set,
    input  logic [NUM_REGS-1:0] i_clr,
    output logic [NUM_REGS-1:0] o_busy_vec
);

    localparam logic [NUM_REGS-1:0] ZERO_MASK = NUM_REGS'(1) << REG_ZERO;

    logic [NUM_REGS-1:0] r_busy;

    // Set has priority over clear; register 0 can never become busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
        end else begin
            r_busy <= (i_set | (r_busy & ~i_clr)) & ~ZERO_MASK;
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port MIPS32 register file with busy scoreboard.
// Optional write-to-read forwarding is compiled in when RF_BYPASS_EN is defined.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned INDEX_WIDTH = 5,
    parameter int unsigned NUM_READ    = 2,
    parameter int unsigned NUM_WRITE   = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*INDEX_WIDTH-1:0] wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_READ*INDEX_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_READ-1:0]             rd_busy,
    input  logic                            rsv_en,
    input  logic [INDEX_WIDTH-1:0]          rsv_addr,
    output logic [NUM_REGS-1:0]             busy_vec
);

    logic [INDEX_WIDTH-1:0] w_waddr  [MAX_WRITE];
    logic [DATA_WIDTH-1:0]  w_wdata  [MAX_WRITE];
    logic [INDEX_WIDTH-1:0] w_raddr  [NUM_READ];
    logic [MAX_WRITE-1:0]   w_wr_hit [NUM_REGS];
    wr_sel_t                w_wsel   [NUM_REGS];
    logic [NUM_REGS-1:0]    w_set;
    logic [NUM_REGS-1:0]    w_clr;
    logic [DATA_WIDTH-1:0]  r_regs   [NUM_REGS];

    // Unpack write ports; priority slots beyond NUM_WRITE stay idle.
    always_comb begin
        for (int unsigned p = 0; p < MAX_WRITE; p++) begin
            w_waddr[p] = '0;
            w_wdata[p] = '0;
        end
        for (int unsigned p = 0; p < NUM_WRITE; p++) begin
            w_waddr[p] = INDEX_WIDTH'(get_field(MAX_BUS_W'(wr_addr), p, INDEX_WIDTH));
            w_wdata[p] = DATA_WIDTH'(get_field(MAX_BUS_W'(wr_data), p, DATA_WIDTH));
        end
    end

    // Unpack read addresses.
    always_comb begin
        for (int unsigned q = 0; q < NUM_READ; q++) begin
            w_raddr[q] = INDEX_WIDTH'(get_field(MAX_BUS_W'(rd_addr), q, INDEX_WIDTH));
        end
    end

    // Write decode: only legal, non-zero registers can be hit.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_wr_hit[r] = '0;
        end
        for (int unsigned r = REG_ZERO + 1; r < NUM_REGS; r++) begin
            for (int unsigned p = 0; p < NUM_WRITE; p++) begin
                w_wr_hit[r][p] = wr_en[p] && (w_waddr[p] == INDEX_WIDTH'(r));
            end
        end
    end

    // Per-register arbitration plus scoreboard set/clear requests.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_wsel[r] = wr_resolve(w_wr_hit[r]);
            w_clr[r]  = w_wsel[r].hit;
            w_set[r]  = rsv_en && (rsv_addr == INDEX_WIDTH'(r)) && (r != REG_ZERO);
        end
    end

    // Storage array; register 0 is held at its reset value forever.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = REG_ZERO + 1; r < NUM_REGS; r++) begin
                if (w_wsel[r].hit) begin
                    r_regs[r] <= w_wdata[w_wsel[r].port];
                end
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .i_set      (w_set),
        .i_clr      (w_clr),
        .o_busy_vec (busy_vec)
    );

    // Read muxes; address 0 and out-of-range addresses fall through to zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned q = 0; q < NUM_READ; q++) begin
            for (int unsigned r = REG_ZERO + 1; r < NUM_REGS; r++) begin
                if (w_raddr[q] == INDEX_WIDTH'(r)) begin
                    rd_data[q*DATA_WIDTH +: DATA_WIDTH] = r_regs[r];
                    rd_busy[q]                          = busy_vec[r];
`ifdef RF_BYPASS_EN
                    if (rstn && w_wsel[r].hit) begin
                        rd_data[q*DATA_WIDTH +: DATA_WIDTH] = w_wdata[w_wsel[r].port];
                        if (!w_set[r]) begin
                            rd_busy[q] = 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

endmodule
